decoder_nx2n_scan: RTL and testbench

DECODER_NX2N_SCAN -- requirements
Module: decoder_nx2n_scan

---
 rtl/decoder_nx2n_scan.sv | 127 ++++++++++++
 tb/tb_decoder_nx2n_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx2n_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nx2n_scan
// Purpose  : N-to-2^N one-hot decoder with an auto-scan mode. In decode mode
//            y follows onehot(a) with one cycle of latency. In scan mode the
//            asserted bit starts at a and steps upward, holding each position
//            for dwell+1 cycles and pulsing wrap on the 2^N-1 -> 0 step.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            en     - output enable (0 forces all outputs inactive)
//            mode   - 0 = decode, 1 = scan
//            a      - decode select / scan start index
//            dwell  - extra cycles held per scan position
//            y      - registered one-hot (or all-zero) output
//            idx    - index of the asserted y bit
//            valid  - high when one bit of y is asserted
//            wrap   - one-cycle pulse on scan wrap-around
// Revision : 1.0 - initial release
// ============================================================================
module decoder_nx2n_scan #(
   parameter int N       = 2,
   parameter int DWELL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic [N-1:0]         a,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [(1<<N)-1:0]    y,
   output logic [N-1:0]         idx,
   output logic                 valid,
   output logic                 wrap
);

   localparam int           c_ny      = 1 << N;
   localparam logic [N-1:0] c_idx_max = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DWELL_W-1:0]   r_cnt;
   logic [DWELL_W-1:0]   w_cnt_nxt;
   logic [DWELL_W-1:0]   r_dwell;
   logic [DWELL_W-1:0]   w_dwell_nxt;
   logic [N-1:0]         r_idx;
   logic [N-1:0]         w_idx_nxt;
   logic [c_ny-1:0]      r_y;
   logic [c_ny-1:0]      w_y_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic                 r_wrap;
   logic                 w_wrap_nxt;

   // Next state depends only on en/mode; the output registers are loaded
   // with the values belonging to the state being entered, so every output
   // is a flop and y is derived from the same next index as idx.
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_cnt_nxt   = '0;
      w_dwell_nxt = r_dwell;

      if (en) begin
         if (!mode) begin
            w_state_nxt = ST_DECODE;
            w_idx_nxt   = a;
            w_valid_nxt = 1'b1;
         end else begin
            w_state_nxt = ST_SCAN;
            w_valid_nxt = 1'b1;
            if (r_state != ST_SCAN) begin
               // Scan entry: start at a and latch the dwell for this position.
               w_idx_nxt   = a;
               w_dwell_nxt = dwell;
            end else if (r_cnt == r_dwell) begin
               // Position finished: step, and re-sample dwell for the new one.
               w_idx_nxt   = r_idx + N'(1);
               w_dwell_nxt = dwell;
               w_wrap_nxt  = (r_idx == c_idx_max);
            end else begin
               w_idx_nxt   = r_idx;
               w_cnt_nxt   = r_cnt + DWELL_W'(1);
            end
         end
      end

      w_y_nxt = '0;
      if (w_valid_nxt) begin
         w_y_nxt[w_idx_nxt] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dwell <= '0;
         r_idx   <= '0;
         r_y     <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dwell <= w_dwell_nxt;
         r_idx   <= w_idx_nxt;
         r_y     <= w_y_nxt;
         r_valid <= w_valid_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign y     = r_y;
   assign idx   = r_idx;
   assign valid = r_valid;
   assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nx2n_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_nx2n_scan
// Purpose  : Self-checking bench for decoder_nx2n_scan. Three instances
//            (N=1,2,3) share the stimulus; a position/countdown reference
//            model predicts each one, plus directed scenarios with fixed
//            expected sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nx2n_scan;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [2:0] a;
   logic [3:0] dwell;

   logic [1:0] y1;
   logic [0:0] idx1;
   logic       valid1;
   logic       wrap1;
   logic [3:0] y2;
   logic [1:0] idx2;
   logic       valid2;
   logic       wrap2;
   logic [7:0] y3;
   logic [2:0] idx3;
   logic       valid3;
   logic       wrap3;

   int n_checks;
   int n_errors;
   int cyc;

   // reference model state per instance (k = 0,1,2 -> N = 1,2,3)
   int m_st   [3];   // 0 idle, 1 decode, 2 scan
   int m_pos  [3];
   int m_left [3];   // cycles still to spend at the current scan position
   int m_wrap [3];

   decoder_nx2n_scan #(.N(1), .DWELL_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a[0:0]), .dwell(dwell),
      .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1));

   decoder_nx2n_scan #(.N(2), .DWELL_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a[1:0]), .dwell(dwell),
      .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2));

   decoder_nx2n_scan #(.N(3), .DWELL_W(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .dwell(dwell),
      .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // Behavioural rules: idle clears, decode follows a, scan holds each
   // position dwell+1 cycles then steps modulo the output width.
   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int size;
         size = 1 << (k + 1);
         m_wrap[k] = 0;
         if (!rst_n || !en) begin
            m_st[k]  = 0;
            m_pos[k] = 0;
         end else if (!mode) begin
            m_st[k]  = 1;
            m_pos[k] = int'(a) % size;
         end else if (m_st[k] != 2) begin
            m_st[k]   = 2;
            m_pos[k]  = int'(a) % size;
            m_left[k] = int'(dwell) + 1;
         end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
               m_pos[k]  = (m_pos[k] + 1) % size;
               m_wrap[k] = (m_pos[k] == 0) ? 1 : 0;
               m_left[k] = int'(dwell) + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] gy, gi, gv, gw, ey;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin gy = 32'(y1); gi = 32'(idx1); gv = 32'(valid1); gw = 32'(wrap1); end
            1:       begin gy = 32'(y2); gi = 32'(idx2); gv = 32'(valid2); gw = 32'(wrap2); end
            default: begin gy = 32'(y3); gi = 32'(idx3); gv = 32'(valid3); gw = 32'(wrap3); end
         endcase
         ey = (m_st[k] != 0) ? (32'd1 << m_pos[k]) : 32'd0;
         check_val($sformatf("y_n%0d", k + 1), gy, ey);
         check_val($sformatf("idx_n%0d", k + 1), gi, 32'(m_pos[k]));
         check_val($sformatf("valid_n%0d", k + 1), gv, (m_st[k] != 0) ? 32'd1 : 32'd0);
         check_val($sformatf("wrap_n%0d", k + 1), gw, 32'(m_wrap[k]));
         check_val($sformatf("onehot0_n%0d", k + 1), $onehot0(gy) ? 32'd1 : 32'd0, 32'd1);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      compare_all();
      cyc++;
   endtask

   logic [3:0] exp_scan_y    [7];
   logic       exp_scan_wrap [7];

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_pos[k] = 0; m_left[k] = 0; m_wrap[k] = 0;
      end
      exp_scan_y    = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
      exp_scan_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      // reset has priority over en/mode
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; a = 3'd5; dwell = 4'd2;
      cycle();
      cycle();
      check_val("reset_y", 32'(y2), 32'd0);
      check_val("reset_valid", 32'(valid3), 32'd0);

      // decode sweep
      rst_n = 1'b1; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 3'(i);
         cycle();
         check_val("dec_sweep_y", 32'(y2), 32'd1 << i);
         check_val("dec_sweep_valid", 32'(valid2), 32'd1);
      end

      // enable drop in decode
      a = 3'd2;
      cycle();
      en = 1'b0;
      cycle();
      check_val("en_drop_y", 32'(y2), 32'd0);
      check_val("en_drop_idx", 32'(idx2), 32'd0);

      // scan N=2, dwell=1, start at 2; a is changed after entry and ignored
      en = 1'b1; mode = 1'b1; dwell = 4'd1; a = 3'd2;
      for (int i = 0; i < 7; i++) begin
         cycle();
         if (i == 0) a = 3'd0;
         check_val("scan_d1_y", 32'(y2), 32'(exp_scan_y[i]));
         check_val("scan_d1_wrap", 32'(wrap2), 32'(exp_scan_wrap[i]));
      end

      // scan N=3, dwell=0, start at 7
      en = 1'b0;
      cycle();
      en = 1'b1; dwell = 4'd0; a = 3'd7;
      cycle();
      check_val("scan_n3_pos0", 32'(y3), 32'h80);
      cycle();
      check_val("scan_n3_pos1", 32'(y3), 32'h01);
      check_val("scan_n3_wrap", 32'(wrap3), 32'd1);
      cycle();
      check_val("scan_n3_pos2", 32'(y3), 32'h02);

      // reset mid-scan at idx=3, then restart from a
      en = 1'b0;
      cycle();
      en = 1'b1; a = 3'd0;
      for (int i = 0; i < 4; i++) cycle();
      check_val("pre_reset_idx", 32'(idx2), 32'd3);
      rst_n = 1'b0;
      cycle();
      check_val("mid_reset_y", 32'(y2), 32'd0);
      check_val("mid_reset_valid", 32'(valid2), 32'd0);
      rst_n = 1'b1; a = 3'd1;
      cycle();
      check_val("restart_y", 32'(y2), 32'b0010);

      // scan -> decode switch with a=3
      mode = 1'b0; a = 3'd3;
      cycle();
      check_val("switch_y", 32'(y2), 32'b1000);
      check_val("switch_wrap", 32'(wrap2), 32'd0);

      // randomized stimulus against the model
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         en    = ($urandom_range(0, 15) != 0);
         mode  = ($urandom_range(0, 3) != 0);
         a     = 3'($urandom);
         dwell = 4'($urandom_range(0, 3));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
